// File: rtl/meduram_bank.sv
// meduram_bank: one 1W1R synchronous memory bank with a registered read port.
// Storage is not reset; only the read register clears on arstn-style reset.
module meduram_bank #(
    parameter int ADDR_WIDTH = 9,
    parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] wraddr,
    input  logic [DATA_WIDTH-1:0] wrdata,
    input  logic                  rden,
    input  logic [ADDR_WIDTH-1:0] rdaddr,
    output logic [DATA_WIDTH-1:0] rddata
);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    // Write port: storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wren) begin
            mem[wraddr] <= wrdata;
        end
    end

    // Registered read; a same-address write in this cycle is not yet visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rddata <= '0;
        end else if (rden) begin
            rddata <= mem[rdaddr];
        end
    end

endmodule

// File: rtl/top_2w_2r_ram.sv
// top_2w_2r_ram: 2-write / 2-read RAM built as a live-value table over a
// 2x2 grid of meduram_bank instances (bank[w][r]).
// Optional macro RDW_BYPASS_EN: a read of an address written in the same
// cycle returns the new data (port 2 wins a collision). Without it the old
// word is returned.
module top_2w_2r_ram #(
    parameter int ADDR_WIDTH = 9,
    parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  aclk,
    input  logic                  arstn,
    input  logic                  wren1,
    input  logic [ADDR_WIDTH-1:0] wraddr1,
    input  logic [DATA_WIDTH-1:0] wrdata1,
    input  logic                  wren2,
    input  logic [ADDR_WIDTH-1:0] wraddr2,
    input  logic [DATA_WIDTH-1:0] wrdata2,
    input  logic                  rden1,
    input  logic [ADDR_WIDTH-1:0] rdaddr1,
    output logic [DATA_WIDTH-1:0] rddata1,
    input  logic                  rden2,
    input  logic [ADDR_WIDTH-1:0] rdaddr2,
    output logic [DATA_WIDTH-1:0] rddata2
);

    logic                  wr_en   [2];
    logic [ADDR_WIDTH-1:0] wr_addr [2];
    logic [DATA_WIDTH-1:0] wr_data [2];
    logic                  rd_en   [2];
    logic [ADDR_WIDTH-1:0] rd_addr [2];
    logic [DATA_WIDTH-1:0] rd_data [2];

    logic [DATA_WIDTH-1:0] bank_q  [2][2];   // [write port][read port]
    logic [RAM_DEPTH-1:0]  lvt;              // 0 = port 1 wrote last, 1 = port 2
    logic                  rd_sel  [2];      // registered LVT lookup per read port

    // Port bundling; bank writes are gated so enables are ignored during reset.
    always_comb begin
        wr_en[0]   = wren1 & arstn;
        wr_en[1]   = wren2 & arstn;
        wr_addr[0] = wraddr1;
        wr_addr[1] = wraddr2;
        wr_data[0] = wrdata1;
        wr_data[1] = wrdata2;
        rd_en[0]   = rden1;
        rd_en[1]   = rden2;
        rd_addr[0] = rdaddr1;
        rd_addr[1] = rdaddr2;
    end

    // Each write port owns one bank per read port and writes both of them.
    for (genvar w = 0; w < 2; w++) begin : g_wr
        for (genvar r = 0; r < 2; r++) begin : g_rd
            meduram_bank #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .RAM_DEPTH  (RAM_DEPTH),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_bank (
                .clk    (aclk),
                .rst_n  (arstn),
                .wren   (wr_en[w]),
                .wraddr (wr_addr[w]),
                .wrdata (wr_data[w]),
                .rden   (rd_en[r]),
                .rdaddr (rd_addr[r]),
                .rddata (bank_q[w][r])
            );
        end
    end

    // Live-value table: port 2 is applied after port 1 so it wins a collision.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            lvt <= '0;
        end else begin
            if (wren1) begin
                lvt[wraddr1] <= 1'b0;
            end
            if (wren2) begin
                lvt[wraddr2] <= 1'b1;
            end
        end
    end

    // Sample the pre-write LVT entry alongside the bank read so the pair
    // stays aligned; this yields the old word on a read-during-write.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            for (int unsigned r = 0; r < 2; r++) begin
                rd_sel[r] <= 1'b0;
            end
        end else begin
            for (int unsigned r = 0; r < 2; r++) begin
                if (rd_en[r]) begin
                    rd_sel[r] <= lvt[rd_addr[r]];
                end
            end
        end
    end

`ifdef RDW_BYPASS_EN
    logic                  byp     [2];
    logic [DATA_WIDTH-1:0] byp_data[2];

    // Capture same-cycle write data for a matching read; port 2 checked first.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            for (int unsigned r = 0; r < 2; r++) begin
                byp[r]      <= 1'b0;
                byp_data[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < 2; r++) begin
                if (rd_en[r]) begin
                    if (wren2 && (wraddr2 == rd_addr[r])) begin
                        byp[r]      <= 1'b1;
                        byp_data[r] <= wrdata2;
                    end else if (wren1 && (wraddr1 == rd_addr[r])) begin
                        byp[r]      <= 1'b1;
                        byp_data[r] <= wrdata1;
                    end else begin
                        byp[r]      <= 1'b0;
                    end
                end
            end
        end
    end

    // Output select: bypass register first, otherwise the live bank.
    always_comb begin
        for (int unsigned r = 0; r < 2; r++) begin
            rd_data[r] = rd_sel[r] ? bank_q[1][r] : bank_q[0][r];
            if (byp[r]) begin
                rd_data[r] = byp_data[r];
            end
        end
    end
`else
    // Output select: the bank written last for the sampled address.
    always_comb begin
        for (int unsigned r = 0; r < 2; r++) begin
            rd_data[r] = rd_sel[r] ? bank_q[1][r] : bank_q[0][r];
        end
    end
`endif

    assign rddata1 = rd_data[0];
    assign rddata2 = rd_data[1];

endmodule

// File: tb/tb_top_2w_2r_ram.sv
// tb_top_2w_2r_ram: directed and randomized checks of top_2w_2r_ram against
// a word-level memory model (last write wins, port 2 after port 1).
module tb_top_2w_2r_ram;

    localparam int AW    = 9;
    localparam int DEPTH = 2**AW;
    localparam int DW    = 64;

    logic          aclk = 1'b0;
    logic          arstn;
    logic          wren1, wren2, rden1, rden2;
    logic [AW-1:0] wraddr1, wraddr2, rdaddr1, rdaddr2;
    logic [DW-1:0] wrdata1, wrdata2, rddata1, rddata2;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] mem_m [DEPTH];
    bit            known [DEPTH];
    logic [DW-1:0] exp1, exp2;
    bit            v1, v2;

    top_2w_2r_ram #(
        .ADDR_WIDTH (AW),
        .RAM_DEPTH  (DEPTH),
        .DATA_WIDTH (DW)
    ) dut (
        .aclk    (aclk),
        .arstn   (arstn),
        .wren1   (wren1),
        .wraddr1 (wraddr1),
        .wrdata1 (wrdata1),
        .wren2   (wren2),
        .wraddr2 (wraddr2),
        .wrdata2 (wrdata2),
        .rden1   (rden1),
        .rdaddr1 (rdaddr1),
        .rddata1 (rddata1),
        .rden2   (rden2),
        .rdaddr2 (rdaddr2),
        .rddata2 (rddata2)
    );

    always #5 aclk = ~aclk;

    task automatic idle();
        wren1 = 1'b0; wren2 = 1'b0; rden1 = 1'b0; rden2 = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        exp1 = '0; exp2 = '0; v1 = 1'b1; v2 = 1'b1;
    endtask

    function automatic void predict(input logic [AW-1:0] a,
                                    output logic [DW-1:0] d, output bit v);
`ifdef RDW_BYPASS_EN
        if (wren2 && wraddr2 == a) begin d = wrdata2; v = 1'b1; return; end
        if (wren1 && wraddr1 == a) begin d = wrdata1; v = 1'b1; return; end
`endif
        d = mem_m[a];
        v = known[a];
    endfunction

    // Advance one clock: predict reads, apply writes, then sample at edge+1.
    task automatic tick();
        if (rden1) predict(rdaddr1, exp1, v1);
        if (rden2) predict(rdaddr2, exp2, v2);
        if (wren1) begin mem_m[wraddr1] = wrdata1; known[wraddr1] = 1'b1; end
        if (wren2) begin mem_m[wraddr2] = wrdata2; known[wraddr2] = 1'b1; end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        wraddr1 = '0; wraddr2 = '0; rdaddr1 = '0; rdaddr2 = '0;
        wrdata1 = '0; wrdata2 = '0;
        arstn = 1'b0;
        model_reset();
        #2;
        checks++;
        if (rddata1 !== '0) begin errors++; $display("FAIL reset_rd1: got %h expected 0", rddata1); end
        checks++;
        if (rddata2 !== '0) begin errors++; $display("FAIL reset_rd2: got %h expected 0", rddata2); end
        repeat (2) @(posedge aclk);
        #3 arstn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_single();
        idle();
        wren1 = 1'b1; wraddr1 = 9'd5; wrdata1 = 64'hA5A5;
        tick();
        idle();
        rden1 = 1'b1; rdaddr1 = 9'd5;
        tick();
        idle();
        checks++;
        if (rddata1 !== 64'hA5A5) begin errors++; $display("FAIL single_wr_rd: got %h expected %h", rddata1, 64'hA5A5); end
    endtask

    task automatic test_parallel();
        idle();
        wren1 = 1'b1; wraddr1 = 9'd3; wrdata1 = 64'h11;
        wren2 = 1'b1; wraddr2 = 9'd4; wrdata2 = 64'h22;
        tick();
        idle();
        rden1 = 1'b1; rdaddr1 = 9'd3; rden2 = 1'b1; rdaddr2 = 9'd4;
        tick();
        checks++;
        if (rddata1 !== 64'h11) begin errors++; $display("FAIL parallel_rd1: got %h expected 11", rddata1); end
        checks++;
        if (rddata2 !== 64'h22) begin errors++; $display("FAIL parallel_rd2: got %h expected 22", rddata2); end
        rdaddr1 = 9'd4; rdaddr2 = 9'd3;
        tick();
        idle();
        checks++;
        if (rddata1 !== 64'h22) begin errors++; $display("FAIL parallel_swap_rd1: got %h expected 22", rddata1); end
        checks++;
        if (rddata2 !== 64'h11) begin errors++; $display("FAIL parallel_swap_rd2: got %h expected 11", rddata2); end
    endtask

    task automatic test_collision();
        idle();
        wren1 = 1'b1; wraddr1 = 9'd7; wrdata1 = 64'h1;
        wren2 = 1'b1; wraddr2 = 9'd7; wrdata2 = 64'h2;
        tick();
        idle();
        rden1 = 1'b1; rdaddr1 = 9'd7; rden2 = 1'b1; rdaddr2 = 9'd7;
        tick();
        idle();
        checks++;
        if (rddata1 !== 64'h2) begin errors++; $display("FAIL collision_rd1: got %h expected 2", rddata1); end
        checks++;
        if (rddata2 !== 64'h2) begin errors++; $display("FAIL collision_rd2: got %h expected 2", rddata2); end
    endtask

    task automatic test_overwrite();
        idle();
        wren1 = 1'b1; wraddr1 = 9'd9; wrdata1 = 64'hAA;
        tick();
        idle();
        wren2 = 1'b1; wraddr2 = 9'd9; wrdata2 = 64'hBB;
        tick();
        idle();
        rden1 = 1'b1; rdaddr1 = 9'd9;
        tick();
        idle();
        checks++;
        if (rddata1 !== 64'hBB) begin errors++; $display("FAIL overwrite_p2: got %h expected bb", rddata1); end
        wren1 = 1'b1; wraddr1 = 9'd9; wrdata1 = 64'hCC;
        tick();
        idle();
        rden1 = 1'b1; rdaddr1 = 9'd9; rden2 = 1'b1; rdaddr2 = 9'd9;
        tick();
        idle();
        checks++;
        if (rddata1 !== 64'hCC) begin errors++; $display("FAIL overwrite_p1_rd1: got %h expected cc", rddata1); end
        checks++;
        if (rddata2 !== 64'hCC) begin errors++; $display("FAIL overwrite_p1_rd2: got %h expected cc", rddata2); end
    endtask

    task automatic test_rdw();
        logic [DW-1:0] want;
        idle();
        wren1 = 1'b1; wraddr1 = 9'd10; wrdata1 = 64'h5;
        tick();
        idle();
        wren1 = 1'b1; wraddr1 = 9'd10; wrdata1 = 64'h6;
        rden1 = 1'b1; rdaddr1 = 9'd10; rden2 = 1'b1; rdaddr2 = 9'd10;
        tick();
        idle();
`ifdef RDW_BYPASS_EN
        want = 64'h6;
`else
        want = 64'h5;
`endif
        checks++;
        if (rddata1 !== want) begin errors++; $display("FAIL rdw_rd1: got %h expected %h", rddata1, want); end
        checks++;
        if (rddata2 !== want) begin errors++; $display("FAIL rdw_rd2: got %h expected %h", rddata2, want); end
        rden1 = 1'b1; rdaddr1 = 9'd10;
        tick();
        idle();
        checks++;
        if (rddata1 !== 64'h6) begin errors++; $display("FAIL rdw_after: got %h expected 6", rddata1); end
        // Collision while reading the same address
        wren2 = 1'b1; wraddr2 = 9'd11; wrdata2 = 64'h3;
        tick();
        idle();
        wren1 = 1'b1; wraddr1 = 9'd11; wrdata1 = 64'h7;
        wren2 = 1'b1; wraddr2 = 9'd11; wrdata2 = 64'h8;
        rden1 = 1'b1; rdaddr1 = 9'd11;
        tick();
        idle();
`ifdef RDW_BYPASS_EN
        want = 64'h8;
`else
        want = 64'h3;
`endif
        checks++;
        if (rddata1 !== want) begin errors++; $display("FAIL rdw_collision: got %h expected %h", rddata1, want); end
    endtask

    task automatic test_hold();
        logic [DW-1:0] h1, h2;
        idle();
        rden1 = 1'b1; rdaddr1 = 9'd5; rden2 = 1'b1; rdaddr2 = 9'd9;
        tick();
        idle();
        h1 = 64'hA5A5; h2 = 64'hCC;
        for (int i = 0; i < 3; i++) begin
            rdaddr1 = 9'd3; rdaddr2 = 9'd4;
            wren1 = 1'b1; wraddr1 = 9'd5; wrdata1 = 64'hDEAD;
            tick();
            idle();
            checks++;
            if (rddata1 !== h1) begin errors++; $display("FAIL hold_rd1 cyc%0d: got %h expected %h", i, rddata1, h1); end
            checks++;
            if (rddata2 !== h2) begin errors++; $display("FAIL hold_rd2 cyc%0d: got %h expected %h", i, rddata2, h2); end
        end
    endtask

    task automatic test_reset_midtraffic();
        idle();
        wren1 = 1'b1; wraddr1 = 9'd20; wrdata1 = 64'h1234;
        wren2 = 1'b1; wraddr2 = 9'd21; wrdata2 = 64'h5678;
        rden1 = 1'b1; rdaddr1 = 9'd9; rden2 = 1'b1; rdaddr2 = 9'd5;
        #3 arstn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (rddata1 !== '0) begin errors++; $display("FAIL midreset_rd1: got %h expected 0", rddata1); end
        checks++;
        if (rddata2 !== '0) begin errors++; $display("FAIL midreset_rd2: got %h expected 0", rddata2); end
        repeat (2) @(posedge aclk);
        #1;
        checks++;
        if (rddata1 !== '0 || rddata2 !== '0) begin
            errors++; $display("FAIL reset_ignores_en: got %h/%h expected 0/0", rddata1, rddata2);
        end
        idle();
        #2 arstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rdaddr1 = 9'd9; rdaddr2 = 9'd5;
            tick();
            checks++;
            if (rddata1 !== '0 || rddata2 !== '0) begin
                errors++; $display("FAIL postreset_hold cyc%0d: got %h/%h expected 0/0", i, rddata1, rddata2);
            end
        end
        wren2 = 1'b1; wraddr2 = 9'd20; wrdata2 = 64'hBEEF;
        tick();
        idle();
        rden1 = 1'b1; rdaddr1 = 9'd20;
        tick();
        idle();
        checks++;
        if (rddata1 !== 64'hBEEF) begin errors++; $display("FAIL resume_rd1: got %h expected beef", rddata1); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wren1   = ($urandom_range(0, 99) < 50);
            wren2   = ($urandom_range(0, 99) < 50);
            rden1   = ($urandom_range(0, 99) < 60);
            rden2   = ($urandom_range(0, 99) < 60);
            wraddr1 = 9'($urandom_range(0, 15));
            wraddr2 = 9'($urandom_range(0, 15));
            rdaddr1 = 9'($urandom_range(0, 15));
            rdaddr2 = 9'($urandom_range(0, 15));
            wrdata1 = {$urandom(), $urandom()};
            wrdata2 = {$urandom(), $urandom()};
            tick();
            if (v1) begin
                checks++;
                if (rddata1 !== exp1) begin errors++; $display("FAIL random_rd1 n=%0d: got %h expected %h", n, rddata1, exp1); end
            end
            if (v2) begin
                checks++;
                if (rddata2 !== exp2) begin errors++; $display("FAIL random_rd2 n=%0d: got %h expected %h", n, rddata2, exp2); end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_parallel();
        test_collision();
        test_overwrite();
        test_rdw();
        test_hold();
        test_reset_midtraffic();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/top_2w_2r_ram.md
TOP_2W_2R_RAM -- requirements
Module: top_2w_2r_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, address bits per port.
REQ-002 SHALL have parameter RAM_DEPTH, default 2**ADDR_WIDTH (512), number of words.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, bits per word.
REQ-004 SHALL have port aclk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port arstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports wren1/wren2  input  1  write enables, ports 1/2.
REQ-007 SHALL have ports wraddr1/wraddr2  input  ADDR_WIDTH  write addresses.
REQ-008 SHALL have ports wrdata1/wrdata2  input  DATA_WIDTH  write data.
REQ-009 SHALL have ports rden1/rden2  input  1  read enables, ports 1/2.
REQ-010 SHALL have ports rdaddr1/rdaddr2  input  ADDR_WIDTH  read addresses.
REQ-011 SHALL have ports rddata1/rddata2  output  DATA_WIDTH  registered read data.
REQ-012 SHALL keep port order: aclk, arstn, wren1, wraddr1, wrdata1, wren2, wraddr2, wrdata2, rden1, rdaddr1, rddata1, rden2, rdaddr2, rddata2 (positional instantiation).

Function
REQ-013 SHALL be a 2-write/2-read RAM; all four ports independent and usable every cycle.
REQ-014 SHALL commit a write on a rising edge with wrenN=1; the word is readable from the next edge.
REQ-015 SHALL give 1-cycle read latency: rddataN updates on the edge where rdenN=1 with mem[rdaddrN].
REQ-016 SHALL hold rddataN unchanged while rdenN=0.
REQ-017 SHALL be implemented as a live-value table (LVT): 2x2 banks of 1W1R memory (bank[w][r]), where every write port w writes both of its banks.
REQ-018 SHALL keep an LVT of RAM_DEPTH one-bit entries recording the last write port per address; the read mux selects bank[LVT[rdaddr]][r].
REQ-019 SHALL resolve both writes to the same address in one cycle in favour of port 2: LVT=port 2, and the stored word is wrdata2.
REQ-020 SHALL, without the macro, return the old word on a read-during-write to the same address.
REQ-021 SHALL return identical data on both read ports for the same address in the same cycle.
REQ-022 SHALL give undefined results for addresses >= RAM_DEPTH; no error flag.

Reset
REQ-023 SHALL, on arstn=0, asynchronously clear rddata1/rddata2 to 0 and all LVT entries to 0 (port 1).
REQ-024 SHALL NOT reset memory bank contents; unwritten words read as undefined.
REQ-025 SHALL ignore all enables while arstn=0 and resume on the first edge after release.

Configuration
REQ-026 SHALL support macro RDW_BYPASS_EN: when defined, a read of an address written in the same cycle returns the new data (the port-2 value if both ports write it); when undefined, REQ-020 applies.

Structure
REQ-027 SHALL place no typedefs in a shared package; parameters remain module-local.
REQ-028 SHALL use one sub-module, meduram_bank: 1W1R synchronous RAM with registered read, instantiated four times.

Verification
REQ-029 SHALL check a single write then read: wren1 at addr 5, data 0xA5A5; next cycle rden1 at addr 5 -> rddata1=0xA5A5 one cycle later.
REQ-030 SHALL check parallel writes: port 1 writes addr 3 = 0x11 and port 2 writes addr 4 = 0x22 in the same cycle; then both ports read 3 and 4 -> 0x11 and 0x22.
REQ-031 SHALL check a write collision: both ports write addr 7 (0x1 and 0x2) -> later reads return 0x2 on both read ports.
REQ-032 SHALL check overwrite across ports: port 1 writes addr 9 = 0xAA, then port 2 writes addr 9 = 0xBB -> read returns 0xBB; a later port 1 write of 0xCC -> read returns 0xCC.
REQ-033 SHALL check read-during-write: addr 10 holds 0x5, then write 0x6 while reading addr 10 -> 0x5 without RDW_BYPASS_EN and 0x6 with it.
REQ-034 SHALL check reset and hold: assert arstn=0 mid-traffic -> rddata1/rddata2=0 immediately; with rden=0, rddata holds its value across 3 cycles.
